// File: rtl/dram_rowcol_sequencer_pkg.sv
// Shared types and helpers for the DRAM row/column access sequencer.
package dram_rowcol_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAS    = 3'd1,
    S_COLMUX = 3'd2,
    S_CAS    = 3'd3,
    S_PRE    = 3'd4,
    S_RCAS   = 3'd5,
    S_RRAS   = 3'd6,
    S_RPRE   = 3'd7
  } state_t;

  // Inactive level of the active-low DRAM strobes.
  localparam logic STROBE_IDLE = 1'b1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer; raises a saturating pending flag on each wrap.
module dram_refresh_timer #(
  parameter int unsigned REFRESH_INTERVAL = 128
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic pending
);

  localparam int unsigned CW = $clog2(REFRESH_INTERVAL);

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap  = (r_cnt == CW'(REFRESH_INTERVAL - 1));
  assign pending = r_pending;

  // A wrap coinciding with a clear means a fresh refresh is owed, so set wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap)
        r_pending <= 1'b1;
      else if (clear)
        r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_rowcol_sequencer.sv
// DRAM access sequencer: latches one host request, drives RAS/mux/CAS/WE timing,
// and interleaves CAS-before-RAS refresh cycles.
module dram_rowcol_sequencer
  import dram_rowcol_sequencer_pkg::*;
#(
  parameter int unsigned ROW_BITS         = 8,
  parameter int unsigned COL_BITS         = 8,
  parameter int unsigned RAS_TO_MUX       = 1,
  parameter int unsigned MUX_TO_CAS       = 1,
  parameter int unsigned CAS_CYCLES       = 2,
  parameter int unsigned PRECHARGE        = 2,
  parameter int unsigned REFRESH_INTERVAL = 128,
  localparam int unsigned AW = max2(ROW_BITS, COL_BITS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req,
  input  logic                         we,
  input  logic [ROW_BITS+COL_BITS-1:0] addr,
  output logic                         ack,
  output logic                         busy,
  output logic                         ras_n,
  output logic                         cas_n,
  output logic                         we_n,
  output logic                         mux,
  output logic [AW-1:0]                dram_addr
);

  localparam int unsigned TMAX = max2(max2(RAS_TO_MUX, MUX_TO_CAS), max2(CAS_CYCLES, PRECHARGE));
  localparam int unsigned CW   = $clog2(TMAX + 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ROW_BITS-1:0]   r_row;
  logic [COL_BITS-1:0]   r_col;
  logic                  r_we;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_ras_n;
  logic                  r_cas_n;
  logic                  r_we_n;
  logic                  r_mux;
  logic [AW-1:0]         r_dram_addr;

  logic                  w_ref_pending;
  logic                  w_ref_clear;
  logic [ROW_BITS-1:0]   w_row_in;
  logic [COL_BITS-1:0]   w_col_in;

  assign w_row_in    = addr[ROW_BITS-1:0];
  assign w_col_in    = addr[ROW_BITS+COL_BITS-1:ROW_BITS];
  assign w_ref_clear = (r_state == S_IDLE) && w_ref_pending;

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_ref_clear),
    .pending(w_ref_pending)
  );

  // Phase counters load LEN-1 on entry and advance when they reach zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_we        <= 1'b0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_ras_n     <= STROBE_IDLE;
      r_cas_n     <= STROBE_IDLE;
      r_we_n      <= STROBE_IDLE;
      r_mux       <= 1'b0;
      r_dram_addr <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ref_pending) begin
            r_cas_n <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RCAS;
          end else if (req) begin
            r_row       <= w_row_in;
            r_col       <= w_col_in;
            r_we        <= we;
            r_dram_addr <= AW'(w_row_in);
            r_ras_n     <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= CW'(RAS_TO_MUX - 1);
            r_state     <= S_RAS;
          end
        end
        S_RAS: begin
          if (r_cnt == '0) begin
            r_mux       <= 1'b1;
            r_dram_addr <= AW'(r_col);
            r_cnt       <= CW'(MUX_TO_CAS - 1);
            r_state     <= S_COLMUX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_COLMUX: begin
          if (r_cnt == '0) begin
            r_cas_n <= 1'b0;
            r_we_n  <= ~r_we;
            r_ack   <= (CAS_CYCLES == 1);
            r_cnt   <= CW'(CAS_CYCLES - 1);
            r_state <= S_CAS;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_CAS: begin
          if (r_cnt == '0) begin
            r_ras_n     <= STROBE_IDLE;
            r_cas_n     <= STROBE_IDLE;
            r_we_n      <= STROBE_IDLE;
            r_mux       <= 1'b0;
            r_dram_addr <= AW'(r_row);
            r_cnt       <= CW'(PRECHARGE - 1);
            r_state     <= S_PRE;
          end else begin
            r_ack <= (r_cnt == CW'(1));
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_PRE, S_RPRE: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RCAS: begin
          r_ras_n <= 1'b0;
          r_cnt   <= CW'(CAS_CYCLES - 1);
          r_state <= S_RRAS;
        end
        S_RRAS: begin
          if (r_cnt == '0) begin
            r_ras_n <= STROBE_IDLE;
            r_cas_n <= STROBE_IDLE;
            r_cnt   <= CW'(PRECHARGE - 1);
            r_state <= S_RPRE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign ras_n     = r_ras_n;
  assign cas_n     = r_cas_n;
  assign we_n      = r_we_n;
  assign mux       = r_mux;
  assign dram_addr = r_dram_addr;

endmodule
